// File: rtl/fifo_pop_referee.sv
// Read-side referee: round-robin pops from four source FIFOs, routes each word to a destination FIFO by bits [DATA_W-1:DATA_W-2].
// Optional build macro STRICT_PRIORITY_EN selects fixed priority (source 0 highest) instead of round-robin.
module fifo_pop_referee #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned N_SRC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [N_SRC-1:0]  src_empty,
  input  logic [DATA_W-1:0] src_data0,
  input  logic [DATA_W-1:0] src_data1,
  input  logic [DATA_W-1:0] src_data2,
  input  logic [DATA_W-1:0] src_data3,
  input  logic [N_SRC-1:0]  dst_almost_full,
  output logic [N_SRC-1:0]  pop,
  output logic [N_SRC-1:0]  push,
  output logic [DATA_W-1:0] data_out,
  output logic              idle
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } ctrl_state_e;

  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  grant;
  logic [1:0]        grant_idx;
  logic [1:0]        idx;
  logic              found;
  logic [1:0]        search_base;
  logic [1:0]        pop_idx;
  logic              s1_v;
  logic [1:0]        s1_sel;
  logic [DATA_W-1:0] s1_word;
  logic [N_SRC-1:0]  push_next;

  // Masking with the current pop stops a second pop before src_empty reflects the first.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    eligible  = ~src_empty & ~pop;
    if (state == ST_ACTIVE && dst_almost_full == '0) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        idx = search_base + 2'(i);
        if (!found && eligible[idx]) begin
          found          = 1'b1;
          grant_idx      = idx;
          grant[idx]     = 1'b1;
        end
      end
    end
  end

`ifdef STRICT_PRIORITY_EN
  always_comb search_base = '0;
`else
  logic [1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  rr_ptr <= '0;
    else if (state == ST_RESET)  rr_ptr <= '0;
    else if (found)              rr_ptr <= grant_idx + 2'd1;
  end

  always_comb search_base = rr_ptr;
`endif

  always_comb begin
    pop_idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++)
      if (pop[i]) pop_idx = 2'(i);
  end

  always_comb begin
    case (s1_sel)
      2'd0:    s1_word = src_data0;
      2'd1:    s1_word = src_data1;
      2'd2:    s1_word = src_data2;
      default: s1_word = src_data3;
    endcase
    push_next = '0;
    push_next[s1_word[DATA_W-1 -: 2]] = 1'b1;
  end

  // Stage 0 is the registered pop; stage 1 waits for the source's registered data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop      <= '0;
      push     <= '0;
      data_out <= '0;
      s1_v     <= 1'b0;
      s1_sel   <= '0;
      idle     <= 1'b1;
    end else if (state == ST_RESET) begin
      pop      <= '0;
      push     <= '0;
      data_out <= '0;
      s1_v     <= 1'b0;
      s1_sel   <= '0;
      idle     <= 1'b1;
    end else begin
      pop    <= grant;
      s1_v   <= |pop;
      s1_sel <= pop_idx;
      if (s1_v) begin
        data_out <= s1_word;
        push     <= push_next;
      end else begin
        push     <= '0;
      end
      idle <= (grant == '0) && (pop == '0) && (src_empty == '1);
    end
  end

endmodule

// File: tb/tb_fifo_pop_referee.sv
// Scoreboard bench for fifo_pop_referee: behavioural source FIFOs, directed loads, in-order push checking.
module tb_fifo_pop_referee;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [3:0]  src_empty = 4'b1111;
  logic [11:0] src_data0 = '0, src_data1 = '0, src_data2 = '0, src_data3 = '0;
  logic [3:0]  dst_almost_full;
  logic [3:0]  pop, push;
  logic [11:0] data_out;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  dst;
    logic [11:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [11:0] q0[$], q1[$], q2[$], q3[$];

  fifo_pop_referee #(.DATA_W(12), .N_SRC(4)) dut (
    .clk(clk), .reset(reset), .state(state), .src_empty(src_empty),
    .src_data0(src_data0), .src_data1(src_data1), .src_data2(src_data2), .src_data3(src_data3),
    .dst_almost_full(dst_almost_full), .pop(pop), .push(push), .data_out(data_out), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO model: pop sampled on the edge, registered data valid the following cycle.
  always @(posedge clk) begin
    if (pop[0]) begin chk("pop_nonempty0", 32'(q0.size() != 0), 1); if (q0.size() != 0) src_data0 <= q0.pop_front(); end
    if (pop[1]) begin chk("pop_nonempty1", 32'(q1.size() != 0), 1); if (q1.size() != 0) src_data1 <= q1.pop_front(); end
    if (pop[2]) begin chk("pop_nonempty2", 32'(q2.size() != 0), 1); if (q2.size() != 0) src_data2 <= q2.pop_front(); end
    if (pop[3]) begin chk("pop_nonempty3", 32'(q3.size() != 0), 1); if (q3.size() != 0) src_data3 <= q3.pop_front(); end
    src_empty <= {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
  end

  always @(negedge clk) begin
    if (push !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_push: got push=%b data=%h expected no push at %0t", push, data_out, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("push_dst", 32'(push), 32'(e.dst));
        chk("push_data", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic load(input int s, input logic [11:0] d, input logic [3:0] dst);
    case (s)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
    exp_q.push_back('{dst: dst, data: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    while (pop == 4'b0000 && n < 30) begin
      tick();
      n++;
    end
    if (pop == 4'b0000) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no pop expected pop within 30 cycles", name);
    end
  endtask

  task automatic pop_seq(input string name, input logic [3:0] seq[6]);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk(name, 32'(pop), 32'(seq[i]));
    end
  endtask

  initial begin
    logic [3:0] seq[6];
    reset = 1'b0;
    state = 4'b0100;
    dst_almost_full = 4'b0000;
    #12;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_idle", 32'(idle), 1);
    reset = 1'b1;
    tick();

    // single source: mask limits to one pop every other cycle
    load(0, 12'h001, 4'b0001);
    load(0, 12'h402, 4'b0010);
    load(0, 12'h803, 4'b0100);
    state = 4'b1000;
    wait_pop("single_start");
    seq = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    pop_seq("single_pop", seq);
    repeat (4) tick();
    chk("single_idle", 32'(idle), 1);

    state = 4'b0001;
    tick();
    state = 4'b1000;

`ifdef STRICT_PRIORITY_EN
    load(0, 12'h001, 4'b0001);
    load(1, 12'h401, 4'b0010);
    load(0, 12'h002, 4'b0001);
    load(1, 12'h402, 4'b0010);
    load(0, 12'h003, 4'b0001);
    load(1, 12'h403, 4'b0010);
    wait_pop("strict_start");
    seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    pop_seq("strict_pop", seq);
    tick();
    chk("strict_end", 32'(pop), 0);
    repeat (4) tick();
`else
    load(0, 12'h010, 4'b0001);
    load(1, 12'h420, 4'b0010);
    load(2, 12'h830, 4'b0100);
    load(3, 12'hC40, 4'b1000);
    load(0, 12'h011, 4'b0001);
    wait_pop("rr_start");
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    pop_seq("rr_pop", seq);
    repeat (4) tick();
    chk("rr_idle", 32'(idle), 1);
`endif

    // destination almost-full stalls new grants; in-flight words still land
    load(1, 12'h501, 4'b0010);
    load(2, 12'h901, 4'b0100);
    load(1, 12'hD02, 4'b1000);
    load(2, 12'h102, 4'b0001);
    wait_pop("af_start");
    chk("af_first", 32'(pop), 32'(4'b0010));
    tick();
    chk("af_second", 32'(pop), 32'(4'b0100));
    dst_almost_full = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("af_stall", 32'(pop), 0);
    end
    dst_almost_full = 4'b0000;
    tick();
    chk("af_resume1", 32'(pop), 32'(4'b0010));
    tick();
    chk("af_resume2", 32'(pop), 32'(4'b0100));
    repeat (4) tick();

    // leaving ACTIVE with a pop outstanding: that word still completes
    load(3, 12'hC33, 4'b1000);
    q3.push_back(12'h333);
    wait_pop("idle_start");
    chk("idle_pop3", 32'(pop), 32'(4'b1000));
    state = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_nopop", 32'(pop), 0);
    end
    chk("idle_busy", 32'(idle), 0);
    state = 4'b1100;
    tick();
    chk("badstate_nopop", 32'(pop), 0);
    q3.delete();
    repeat (3) tick();
    chk("idle_empty", 32'(idle), 1);

    // async reset mid-transfer
    state = 4'b1000;
    load(1, 12'h444, 4'b0010);
    wait_pop("areset_start");
    chk("areset_pop1", 32'(pop), 32'(4'b0010));
    #3;
    reset = 1'b0;
    #1;
    chk("areset_pop", 32'(pop), 0);
    chk("areset_push", 32'(push), 0);
    chk("areset_data", 32'(data_out), 0);
    chk("areset_idle", 32'(idle), 1);
    tick();
    reset = 1'b1;
    tick();
    chk("areset_nopush", 32'(push), 0);
    repeat (8) tick();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_pop_referee.md
Name: fifo_pop_referee

Overview:
- Read-side referee that drains a bank of four transaction-layer FIFOs.
- Arbitrates among non-empty sources, issues a pop to exactly one source, captures the returned 12-bit word and pushes it into one of four destination FIFOs.
- The destination is selected by the word's bits [11:10].
- Obeys the same one-hot control state (RESET/INIT/IDLE/ACTIVE) that drives the FIFOs.

Parameters:
- DATA_W, 12, word width; bits [DATA_W-1:DATA_W-2] form the destination field.
- N_SRC, 4, number of source FIFOs (fixed at 4; the 2-bit pointer logic depends on it).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- state  input  4  control state: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE.
- src_empty  input  4  per-source empty flag; must reflect pops sampled at the previous edge.
- src_data0..src_data3  input  DATA_W each  registered data_out of each source FIFO.
- dst_almost_full  input  4  per-destination almost-full flag.
- pop  output  4  registered one-hot pop to the source FIFOs.
- push  output  4  registered one-hot push to the destination FIFOs.
- data_out  output  DATA_W  word driven to the destinations; valid while any push bit is high.
- idle  output  1  high when no pop is pending or in flight and all sources are empty.

Behaviour:
- Async reset (reset=0):
  - pop, push, data_out = 0; idle = 1.
  - rr_ptr = 0; in-flight pipeline cleared.
  - Takes effect immediately, independent of clk.
- state=0001: same clearing as async reset, applied synchronously.
- state=0010 / 0100, or any non-one-hot encoding:
  - No new pops.
  - Words already in flight still complete their push; words are never dropped.
- state=1000 (ACTIVE): arbitration every cycle.
  - Eligible source = !src_empty[i] and not granted in the previous cycle. This mask prevents a double pop before src_empty updates.
  - Stall rule: no grant while any dst_almost_full bit is high. Conservative, because the destination is unknown before the read.
  - Round-robin: search from rr_ptr upward mod 4; the first eligible source wins.
  - On grant g: pop[g]=1 for one cycle; rr_ptr <= g+1 mod 4.
  - No grant: pop=0; rr_ptr holds.
- Pipeline timing:
  - Cycle N: pop[g] high.
  - Edge N+1: the source FIFO samples pop; its data becomes valid in cycle N+1.
  - Edge N+2: the block registers data_out <= src_data[g] and push[data_out[11:10]] <= 1.
  - Pop-to-push latency is 2 cycles; at most 2 words in flight.
- push is one-hot or zero. push=0 and data_out holds its last value when nothing is delivered.
- Throughput:
  - 1 word/cycle when at least 2 sources are non-empty.
  - 1 word per 2 cycles from a single source (mask rule).
- Destination FIFOs must set almost-full with at least 3 free entries, to absorb 2 in-flight words plus flag lag.
- idle = 1 when pop==0, no word in flight, and src_empty==4'b1111.

Optional Feature:
- Macro STRICT_PRIORITY_EN.
- Defined: fixed priority, source 0 highest; rr_ptr is removed; the previous-cycle mask still applies.
- Undefined: round-robin as above.

Test Plan:
- Async reset mid-transfer: drop reset while pop=0010 with one word in flight -> pop=0, push=0, data_out=0x000 immediately; no push after reset release until a new grant.
- Source 0 holds 0x001, 0x402, 0x803, others empty, ACTIVE:
  - pops=0001 at N, N+2, N+4.
  - push=0001/0x001 at N+2; push=0010/0x402 at N+4; push=0100/0x803 at N+6.
- All four sources non-empty, rr_ptr=0 -> grant order 0,1,2,3,0 on consecutive cycles; pushes follow 2 cycles later in the same order.
- dst_almost_full=0100 raised at cycle M -> no pop from M onward, 2 in-flight words still pushed at M+1/M+2; clearing the flag at K -> pop resumes at K.
- ACTIVE->IDLE while pop=1000 at N -> word from source 3 still pushed at N+2; no further pops; idle=1 once all sources are empty.
- STRICT_PRIORITY_EN, sources 0 and 1 non-empty -> grants alternate 0,1,0,1; source 1 never starves because of the mask.
